// File: rtl/ram_arbiter_v1_if.sv
// Request/response bundle between the requesters and ram_arbiter_v1.
// With RAM_ARB_LOCK_EN defined, the bundle also carries the per-requester req_lock bits.
interface ram_arbiter_v1_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
`ifdef RAM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock;

  modport master (output req_valid, req_we, req_addr, req_wdata, req_lock,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_lock,
                  output req_ready, rsp_valid, rsp_data);
`else
  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/ram_arbiter_v1.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle registered read) among NUM_REQ requesters.
// Optional RAM_ARB_LOCK_EN adds a lock FSM that lets one requester own the RAM across several transfers.
module ram_arbiter_v1 #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ram_arbiter_v1_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_en_o,
  output logic [DATA_WIDTH-1:0] ram_data_in_o,
  input  logic [DATA_WIDTH-1:0] ram_data_out_i
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_REQ-1:0]    eligible_s, grant_s, lock_mask_s;
  logic                  win_s, lock_hold_s;
  logic [PTR_W-1:0]      win_idx_s;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

`ifdef RAM_ARB_LOCK_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_state_e;
  lock_state_e      state_q;
  logic [PTR_W-1:0] owner_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_s && bus.req_lock[win_idx_s]) begin
            state_q <= ST_LOCKED;
            owner_q <= win_idx_s;
          end
        end
        ST_LOCKED: begin
          if (win_s && !bus.req_lock[win_idx_s]) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // While locked only the owner competes, and the pointer holds until the release transfer.
  always_comb begin
    lock_mask_s = '1;
    lock_hold_s = 1'b0;
    if (state_q == ST_LOCKED) begin
      lock_mask_s          = '0;
      lock_mask_s[owner_q] = 1'b1;
      lock_hold_s          = win_s && bus.req_lock[win_idx_s];
    end
  end
`else
  assign lock_mask_s = '1;
  assign lock_hold_s = 1'b0;
`endif

  assign eligible_s = rst_i ? '0 : (bus.req_valid & lock_mask_s);

  // First eligible requester at or after the pointer wins.
  always_comb begin
    grant_s   = '0;
    win_s     = 1'b0;
    win_idx_s = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_s && eligible_s[rr_idx(ptr_q, off)]) begin
        win_s                         = 1'b1;
        win_idx_s                     = rr_idx(ptr_q, off);
        grant_s[rr_idx(ptr_q, off)]   = 1'b1;
      end
    end
  end

  always_comb begin
    ram_wr_en_o   = win_s && bus.req_we[win_idx_s];
    ram_data_in_o = bus.req_wdata[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    if (rst_i) begin
      ram_addr_o = '0;
    end else if (win_s) begin
      ram_addr_o = bus.req_addr[int'(win_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin
      ram_addr_o = addr_q;
    end
  end

  always_comb begin
    addr_d      = ram_addr_o;
    rsp_valid_d = '0;
    ptr_d       = ptr_q;
    if (win_s && !bus.req_we[win_idx_s]) rsp_valid_d = grant_s;
    if (win_s && !lock_hold_s) ptr_d = rr_idx(win_idx_s, 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      addr_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
    end
  end

  // A read accepted just before reset must not surface during the reset cycle.
  assign bus.req_ready = grant_s;
  assign bus.rsp_valid = rst_i ? '0 : rsp_valid_q;
  assign bus.rsp_data  = ram_data_out_i;
endmodule

// File: tb/tb_ram_arbiter_v1.sv
// Directed bench for ram_arbiter_v1 with a behavioural RAM and a response scoreboard.
module tb_ram_arbiter_v1;
  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_v1_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] ram_addr;
  logic          ram_wr_en;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  ram_arbiter_v1 #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .ram_addr_o     (ram_addr),
    .ram_wr_en_o    (ram_wr_en),
    .ram_data_in_o  (ram_din),
    .ram_data_out_i (ram_dout)
  );

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic [NR-1:0] vec;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] last_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic val, input logic w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bus.req_valid[i]            = val;
    bus.req_we[i]               = w;
    bus.req_addr[i*AW +: AW]    = ad;
    bus.req_wdata[i*DW +: DW]   = wd;
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic set_lock(input int i, input logic lk);
    bus.req_lock[i] = lk;
  endtask
`endif

  task automatic step(input logic [NR-1:0] exp_ready);
    rsp_t e;
    int k;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_wr_en", 64'(ram_wr_en), 64'd0);
      check("rst_ram_addr", 64'(ram_addr), 64'd0);
      last_addr = '0;
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_valid", 64'(bus.rsp_valid), 64'(e.vec));
        check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
      end else begin
        check("rsp_idle", 64'(bus.rsp_valid), 64'd0);
      end
      check("ready", 64'(bus.req_ready), 64'(exp_ready));
      if (exp_ready == '0) begin
        check("idle_wr_en", 64'(ram_wr_en), 64'd0);
        check("idle_ram_addr", 64'(ram_addr), 64'(last_addr));
      end else begin
        k = 0;
        for (int i = 0; i < NR; i++) if (exp_ready[i]) k = i;
        wa = bus.req_addr[k*AW +: AW];
        wd = bus.req_wdata[k*DW +: DW];
        check("ram_addr", 64'(ram_addr), 64'(wa));
        check("wr_en", 64'(ram_wr_en), 64'(bus.req_we[k]));
        if (bus.req_we[k]) begin
          check("ram_data_in", 64'(ram_din), 64'(wd));
          ref_mem[wa] = wd;
        end else begin
          sb.push_back('{exp_ready, ref_mem[wa]});
        end
        last_addr = wa;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rst           = 1'b1;
    last_addr     = '0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    @(posedge clk);
    #1;
    // reset with a pending read: no ready, outputs at reset values
    set_req(0, 1'b1, 1'b0, 10'd7, 32'd0);
    step('0);
    step('0);
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 10'd0, 32'd0);
    step(2'b00);

    // write by req0, then read back by req1 on the next cycle
    set_req(0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    step(2'b01);
    set_req(0, 1'b0, 1'b0, 10'd0, 32'd0);
    set_req(1, 1'b1, 1'b0, 10'd5, 32'd0);
    step(2'b10);
    set_req(1, 1'b0, 1'b0, 10'd0, 32'd0);
    step(2'b00);

    // both valid: alternating grants
    set_req(0, 1'b1, 1'b0, 10'd5, 32'd0);
    set_req(1, 1'b1, 1'b0, 10'd6, 32'd0);
    step(2'b01);
    step(2'b10);
    step(2'b01);
    step(2'b10);
    set_req(0, 1'b0, 1'b0, 10'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 10'd0, 32'd0);
    step(2'b00);

    // req0 alone: fill 0..7, then stream reads back-to-back
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, 1'b1, 10'(i), 32'h100 + 32'(i * 17));
      step(2'b01);
    end
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, 1'b0, 10'(i), 32'd0);
      step(2'b01);
    end
    set_req(0, 1'b0, 1'b0, 10'd0, 32'd0);
    step(2'b00);

    // reset right after an accepted read; pointer returns to 0
    set_req(0, 1'b1, 1'b0, 10'd3, 32'd0);
    step(2'b01);
    rst = 1'b1;
    step('0);
    rst = 1'b0;
    set_req(1, 1'b1, 1'b0, 10'd4, 32'd0);
    step(2'b01);
    step(2'b10);
    step(2'b01);
    set_req(0, 1'b0, 1'b0, 10'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 10'd0, 32'd0);
    step(2'b00);

`ifdef RAM_ARB_LOCK_EN
    // req1 owns the RAM for a read-modify-write burst while req0 waits
    set_req(1, 1'b1, 1'b0, 10'd9, 32'd0);
    set_lock(1, 1'b1);
    step(2'b10);
    set_req(0, 1'b1, 1'b0, 10'd1, 32'd0);
    set_req(1, 1'b1, 1'b1, 10'd9, 32'h55);
    step(2'b10);
    set_req(1, 1'b0, 1'b0, 10'd9, 32'd0);
    step(2'b00);
    set_req(1, 1'b1, 1'b0, 10'd9, 32'd0);
    step(2'b10);
    set_req(1, 1'b1, 1'b1, 10'd9, 32'h56);
    set_lock(1, 1'b0);
    step(2'b10);
    set_req(1, 1'b0, 1'b0, 10'd0, 32'd0);
    step(2'b01);
    set_req(0, 1'b0, 1'b0, 10'd0, 32'd0);
    step(2'b00);
`endif

    // idle: no writes, address held, no responses
    for (int i = 0; i < 10; i++) step(2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
